rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//  Boot-time program loader for the Hack instruction ROM. Receives a byte stream (from the
//  UART RX stage) and unpacks it: a 16-bit big-endian word count N, then N big-endian words.
//  Writes the words into the ROM at addresses 0..N-1 and holds the CPU in reset until done.
// PARAMETERS
//  DATA_WIDTH     16  ROM word width; only 16 is supported (elaboration assertion)
//  ADDRESS_WIDTH  6   ROM address width; capacity SIZE = 2**ADDRESS_WIDTH words
// PORTS
//  clk         in   1                 single clock for the whole block
//  rst_n       in   1                 asynchronous, active-low reset
//  start       in   1                 1-cycle pulse; begins a load session
//  byte_in     in   8                 stream byte
//  byte_valid  in   1                 byte_in is valid this cycle
//  byte_ready  out  1                 loader accepts a byte this cycle
//  rom_we      out  1                 drives rom.writeEn
//  rom_addr    out  ADDRESS_WIDTH     drives rom.address_in
//  rom_data    out  DATA_WIDTH        drives rom.data_in
//  busy        out  1                 session in progress
//  done        out  1                 sticky: load completed successfully
//  error       out  1                 sticky: word count exceeds SIZE
//  cpu_hold    out  1                 CPU reset request; high unless done
// BEHAVIOUR
//  Reset values: byte_ready=0, rom_we=0, rom_addr=0, rom_data=0, busy=0, done=0, error=0,
//   cpu_hold=1. Reset mid-session aborts the load; ROM contents are left as they are.
//  All outputs are registered. A byte transfers on the rising edge where byte_valid && byte_ready.
//  FSM states: IDLE, CNT_HI, CNT_LO, W_HI, W_LO, WRITE, DONE, ERROR.
//   IDLE  : byte_ready=0; start -> CNT_HI, busy=1, done=0, error=0, addr counter=0.
//   CNT_HI: byte_ready=1; on transfer, count[15:8]=byte -> CNT_LO.
//   CNT_LO: byte_ready=1; on transfer, count[7:0]=byte. Then count==0 -> DONE (no writes);
//           count>SIZE -> ERROR; otherwise -> W_HI.
//   W_HI  : byte_ready=1; on transfer, rom_data[15:8]=byte -> W_LO.
//   W_LO  : byte_ready=1; on transfer, rom_data[7:0]=byte -> WRITE.
//   WRITE : byte_ready=0; rom_we=1 for exactly one cycle with rom_addr and rom_data stable.
//           Next cycle: rom_we=0. If words written == count -> DONE; else rom_addr+1 -> W_HI.
//   DONE  : busy=0, done=1, cpu_hold=0. start -> CNT_HI (reload; done=0, cpu_hold=1 again).
//   ERROR : busy=0, error=1, cpu_hold=1, byte_ready=0. Only start or reset leaves it.
//  rom_addr/rom_data change only outside WRITE, so the ROM's level-sensitive write latches
//   clean data. rom_addr never wraps: the SIZE check in CNT_LO guarantees count <= SIZE.
//   The word counter is ADDRESS_WIDTH+1 bits wide, so count==SIZE is handled.
//  start is ignored while busy. byte_valid is ignored whenever byte_ready=0; no bytes are
//   buffered. Gaps in byte_valid simply stall the current state.
//  Throughput: one word per 3 cycles at most (W_HI, W_LO, WRITE).
// STRUCTURE
//  hack_pkg: typedef enum logic [2:0] loader_state_t; localparam BYTE_WIDTH=8.
//  Single module, no sub-modules: one FSM process, one datapath register process.
//   The byte-to-word packing is too small to split out.
// TESTING
//  1 reset, start, stream 00 03 | 12 34 | AB CD | 00 07 -> ROM[0..2]=1234,ABCD,0007;
//    exactly 3 rom_we pulses; done=1, cpu_hold=0.
//  2 stream 00 00 -> DONE with zero rom_we pulses; done=1, error=0.
//  3 stream 00 41 (65 > SIZE 64) -> ERROR, error=1, cpu_hold=1, byte_ready=0, no writes;
//    then start + 00 40 + 64 words -> ROM fully written, rom_addr ends at 63.
//  4 byte_valid toggled randomly with 1..5-cycle gaps during test 1 -> identical ROM contents.
//  5 rst_n low after 2nd word -> all outputs at reset values; restart and load 00 01 | BEEF
//    -> ROM[0]=BEEF.
//  6 start pulsed mid-session -> ignored: write count and addresses unchanged.

Source files
------------

// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared types and constants for the Hack ROM loader
package hack_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    W_HI,
    W_LO,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - boot-time byte-stream unpacker that fills the Hack instruction ROM
module rom_loader
  import hack_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [BYTE_WIDTH-1:0]    byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     rom_we,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  output logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     cpu_hold
);

  localparam int SIZE = 2 ** ADDRESS_WIDTH;
  // Word counter is one bit wider than the address so a full-ROM load (count == SIZE) terminates.
  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [16:0] SIZE_L = 17'(SIZE);

  if (DATA_WIDTH != 16) begin : g_bad_width
    $error("rom_loader: only DATA_WIDTH = 16 is supported");
  end

  loader_state_t            state_q, state_d;
  logic [15:0]              count_q, count_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [CW-1:0]            wcnt_q, wcnt_d;
  logic                     ready_q, ready_d;
  logic                     we_q, we_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     hold_q, hold_d;

  logic                     xfer;
  logic [15:0]              cnt_full;
  logic [CW-1:0]            wcnt_inc;
  logic                     last_word;

  assign xfer      = byte_valid && ready_q;
  assign cnt_full  = {count_q[15:8], byte_in};
  assign wcnt_inc  = wcnt_q + CW'(1);
  assign last_word = ({{(16 - CW){1'b0}}, wcnt_inc} == count_q);

  // State and registered outputs; async reset aborts any session in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; start is only honoured in the non-busy states
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start) state_d = CNT_HI;
      CNT_HI:            if (xfer) state_d = CNT_LO;
      CNT_LO: begin
        if (xfer) begin
          if (cnt_full == 16'd0)               state_d = DONE;
          else if ({1'b0, cnt_full} > SIZE_L)  state_d = ERROR;
          else                                 state_d = W_HI;
        end
      end
      W_HI:              if (xfer) state_d = W_LO;
      W_LO:              if (xfer) state_d = WRITE;
      WRITE:             state_d = last_word ? DONE : W_HI;
      default:           state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop aligned with the state
  always_comb begin
    ready_d = (state_d == CNT_HI) || (state_d == CNT_LO) ||
              (state_d == W_HI)   || (state_d == W_LO);
    we_d    = (state_d == WRITE);
    busy_d  = ready_d || we_d;
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
    hold_d  = !done_d;
  end

  // Datapath next values: byte packing, address and word counting; nothing moves during WRITE
  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          addr_d = '0;
          wcnt_d = '0;
        end
      end
      CNT_HI: if (xfer) count_d[15:8] = byte_in;
      CNT_LO: if (xfer) count_d[7:0] = byte_in;
      W_HI:   if (xfer) data_d[DATA_WIDTH-1 -: BYTE_WIDTH] = byte_in;
      W_LO:   if (xfer) data_d[BYTE_WIDTH-1:0] = byte_in;
      WRITE: begin
        wcnt_d = wcnt_inc;
        if (!last_word) addr_d = addr_q + ADDRESS_WIDTH'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign byte_ready = ready_q;
  assign rom_we     = we_q;
  assign rom_addr   = addr_q;
  assign rom_data   = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_hold   = hold_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - self-checking bench for rom_loader with a ROM model and write scoreboard
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        rom_we;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  rom_loader #(.DATA_WIDTH(16), .ADDRESS_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  // ROM model plus a log of every cycle rom_we is high
  logic [15:0] mem [0:63];
  int          log_addr[$];
  logic [15:0] log_data[$];

  always @(negedge clk) begin
    if (rom_we) begin
      mem[rom_addr] <= rom_data;
      log_addr.push_back(int'(rom_addr));
      log_data.push_back(rom_data);
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] words_q[$];

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    int w;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    byte_in = b;
    byte_valid = 1'b1;
    w = 0;
    while (1) begin
      @(negedge clk);
      if (byte_ready) break;
      w++;
      if (w > 100) break;
    end
    n_cmp++;
    if (w > 100) begin
      n_fail++;
      $display("FAIL send_byte_ready: byte_ready=%b required=1 within 100 cycles", byte_ready);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_in = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_load(input int n, input int max_gap, input bit mid_start);
    logic [15:0] nn;
    int w;
    nn = 16'(n);
    log_addr.delete();
    log_data.delete();
    pulse_start();
    send_byte(nn[15:8], max_gap);
    send_byte(nn[7:0], max_gap);
    if (n >= 1 && n <= 64) begin
      for (int i = 0; i < n; i++) begin
        logic [15:0] wd;
        wd = words_q[i];
        send_byte(wd[15:8], max_gap);
        if (mid_start && i == 1) pulse_start();
        send_byte(wd[7:0], max_gap);
      end
    end
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (busy && w < 300);
    n_cmp++;
    if (busy) begin
      n_fail++;
      $display("FAIL session_end: busy=%b required=0 after 300 cycles", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({byte_ready, rom_we, rom_addr, rom_data, busy, done, error, cpu_hold} !==
        {1'b0, 1'b0, 6'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b hold=%b required 0 0 00 0000 0 0 0 1",
               byte_ready, rom_we, rom_addr, rom_data, busy, done, error, cpu_hold);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    words_q = '{16'h1234, 16'hABCD, 16'h0007};
    run_load(3, 0, 1'b0);
    n_cmp++;
    if (log_addr.size() != 3) begin
      n_fail++;
      $display("FAIL basic_write_count: got=%0d required=3", log_addr.size());
    end
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      n_cmp++;
      if (log_addr[i] != i || log_data[i] !== words_q[i] || mem[i] !== words_q[i]) begin
        n_fail++;
        $display("FAIL basic_word%0d: addr=%0d data=%h rom=%h required addr=%0d data=%h",
                 i, log_addr[i], log_data[i], mem[i], i, words_q[i]);
      end
    end
    n_cmp++;
    if ({done, error, cpu_hold, busy, rom_we} !== 5'b10000) begin
      n_fail++;
      $display("FAIL basic_flags: done=%b err=%b hold=%b busy=%b we=%b required 1 0 0 0 0",
               done, error, cpu_hold, busy, rom_we);
    end
  endtask

  task automatic test_empty();
    run_load(0, 0, 1'b0);
    n_cmp++;
    if (log_addr.size() != 0 || {done, error, cpu_hold} !== 3'b100) begin
      n_fail++;
      $display("FAIL empty_load: writes=%0d done=%b err=%b hold=%b required writes=0 1 0 0",
               log_addr.size(), done, error, cpu_hold);
    end
  endtask

  task automatic test_oversize();
    run_load(65, 0, 1'b0);
    n_cmp++;
    if (log_addr.size() != 0 || {error, cpu_hold, byte_ready, done, busy} !== 5'b11000) begin
      n_fail++;
      $display("FAIL oversize_error: writes=%0d err=%b hold=%b rdy=%b done=%b busy=%b required 0 1 1 0 0 0",
               log_addr.size(), error, cpu_hold, byte_ready, done, busy);
    end
    byte_valid = 1'b1;
    repeat (10) begin
      byte_in = 8'($urandom);
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    n_cmp++;
    if (log_addr.size() != 0 || error !== 1'b1 || byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL error_sticky: writes=%0d err=%b rdy=%b required 0 1 0",
               log_addr.size(), error, byte_ready);
    end
    words_q.delete();
    for (int i = 0; i < 64; i++) words_q.push_back(16'($urandom));
    run_load(64, 0, 1'b0);
    n_cmp++;
    if (log_addr.size() != 64) begin
      n_fail++;
      $display("FAIL full_write_count: got=%0d required=64", log_addr.size());
    end
    for (int i = 0; i < 64 && i < log_addr.size(); i++) begin
      n_cmp++;
      if (log_addr[i] != i || mem[i] !== words_q[i]) begin
        n_fail++;
        $display("FAIL full_word%0d: addr=%0d rom=%h required addr=%0d data=%h",
                 i, log_addr[i], mem[i], i, words_q[i]);
      end
    end
    n_cmp++;
    if (rom_addr !== 6'd63 || {done, error} !== 2'b10) begin
      n_fail++;
      $display("FAIL full_end: addr=%0d done=%b err=%b required 63 1 0", rom_addr, done, error);
    end
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 2; r++) begin
      int n;
      if (r == 0) begin
        words_q = '{16'h1234, 16'hABCD, 16'h0007};
        n = 3;
      end else begin
        n = int'($urandom_range(12, 2));
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
      end
      run_load(n, 5, 1'b0);
      n_cmp++;
      if (log_addr.size() != n) begin
        n_fail++;
        $display("FAIL gaps%0d_write_count: got=%0d required=%0d", r, log_addr.size(), n);
      end
      for (int i = 0; i < n; i++) begin
        n_cmp++;
        if (mem[i] !== words_q[i]) begin
          n_fail++;
          $display("FAIL gaps%0d_rom%0d: got=%h required=%h", r, i, mem[i], words_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    logic [15:0] old_w1;
    words_q.delete();
    for (int i = 0; i < 4; i++) words_q.push_back(16'($urandom));
    old_w1 = words_q[1];
    log_addr.delete();
    log_data.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 2; i++) begin
      logic [15:0] wd;
      wd = words_q[i];
      send_byte(wd[15:8], 0);
      send_byte(wd[7:0], 0);
    end
    w = 0;
    while (log_addr.size() < 2 && w < 50) begin
      @(negedge clk);
      w++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({byte_ready, rom_we, rom_addr, rom_data, busy, done, error, cpu_hold} !==
        {1'b0, 1'b0, 6'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1} || log_addr.size() != 2) begin
      n_fail++;
      $display("FAIL midreset_outputs: writes=%0d rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b hold=%b required 2 0 0 00 0000 0 0 0 1",
               log_addr.size(), byte_ready, rom_we, rom_addr, rom_data, busy, done, error, cpu_hold);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    words_q = '{16'hBEEF};
    run_load(1, 0, 1'b0);
    n_cmp++;
    if (mem[0] !== 16'hBEEF || mem[1] !== old_w1 || log_addr.size() != 1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_reload: rom0=%h rom1=%h writes=%0d done=%b required BEEF %h 1 1",
               mem[0], mem[1], log_addr.size(), done, old_w1);
    end
  endtask

  task automatic test_mid_start();
    words_q.delete();
    for (int i = 0; i < 5; i++) words_q.push_back(16'($urandom));
    run_load(5, 2, 1'b1);
    n_cmp++;
    if (log_addr.size() != 5) begin
      n_fail++;
      $display("FAIL midstart_write_count: got=%0d required=5", log_addr.size());
    end
    for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
      n_cmp++;
      if (log_addr[i] != i || log_data[i] !== words_q[i]) begin
        n_fail++;
        $display("FAIL midstart_word%0d: addr=%0d data=%h required addr=%0d data=%h",
                 i, log_addr[i], log_data[i], i, words_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_oversize();
    test_gaps();
    test_reset_mid();
    test_mid_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
